// File: rtl/multicycle_ctrl_if.sv
// Shared instruction/data memory port of the multi-cycle control FSM.
// The controller is the master; the memory answers with mem_ready.
interface multicycle_ctrl_if;
  logic mem_req;
  logic mem_we;
  logic mem_addr_sel;
  logic mem_ready;

  modport master (
    output mem_req,
    output mem_we,
    output mem_addr_sel,
    input  mem_ready
  );

  modport slave (
    input  mem_req,
    input  mem_we,
    input  mem_addr_sel,
    output mem_ready
  );
endinterface

// File: rtl/multicycle_ctrl.sv
// Control FSM for the multi-cycle RV32I datapath.
// Optional retired-instruction counter: define CTRL_PERF_CNT_EN.
module multicycle_ctrl #(
  parameter int MEM_TIMEOUT = 15
) (
  input  logic        clk,
  input  logic        rst_n,
  multicycle_ctrl_if.master m,
  input  logic [6:0]  opcode,
  input  logic        br_taken,
  output logic        ir_we,
  output logic        pc_we,
  output logic        pc_sel,
  output logic        alu_a_sel,
  output logic        alu_b_sel,
  output logic        reg_we,
  output logic [1:0]  wb_sel,
  output logic        trap,
  output logic [2:0]  state,
  output logic [31:0] instret
);

  localparam logic [2:0] S_RESET  = 3'd0;
  localparam logic [2:0] S_FETCH  = 3'd1;
  localparam logic [2:0] S_DECODE = 3'd2;
  localparam logic [2:0] S_EXEC   = 3'd3;
  localparam logic [2:0] S_MEM    = 3'd4;
  localparam logic [2:0] S_WB     = 3'd5;
  localparam logic [2:0] S_TRAP   = 3'd6;

  localparam int CW = (MEM_TIMEOUT > 1) ? $clog2(MEM_TIMEOUT) : 1;

  logic [2:0]    r_state;
  logic [2:0]    w_next;
  logic [CW-1:0] r_wait;

  logic w_opimm, w_ld, w_st, w_br;
  logic w_lui, w_auipc, w_jal, w_legal;
  logic w_in_acc, w_tmo;

  assign w_opimm = (opcode == 7'b0010011);
  assign w_ld    = (opcode == 7'b0000011);
  assign w_st    = (opcode == 7'b0100011);
  assign w_br    = (opcode == 7'b1100011);
  assign w_lui   = (opcode == 7'b0110111);
  assign w_auipc = (opcode == 7'b0010111);
  assign w_jal   = (opcode == 7'b1101111);
  assign w_legal = w_opimm | w_ld | w_st | w_br
                 | w_lui | w_auipc | w_jal;

  assign w_in_acc = (r_state == S_FETCH) || (r_state == S_MEM);

  // Ready on the last allowed cycle still completes the access.
  assign w_tmo = (MEM_TIMEOUT != 0) && w_in_acc && !m.mem_ready
              && (r_wait == CW'(MEM_TIMEOUT - 1));

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_RESET:  w_next = S_FETCH;
      S_FETCH: begin
        if (m.mem_ready)  w_next = S_DECODE;
        else if (w_tmo)   w_next = S_TRAP;
      end
      S_DECODE: w_next = w_legal ? S_EXEC : S_TRAP;
      S_EXEC: begin
        if (w_ld || w_st) w_next = S_MEM;
        else if (w_br)    w_next = S_FETCH;
        else              w_next = S_WB;
      end
      S_MEM: begin
        if (m.mem_ready)  w_next = w_st ? S_FETCH : S_WB;
        else if (w_tmo)   w_next = S_TRAP;
      end
      S_WB:     w_next = S_FETCH;
      S_TRAP:   w_next = S_TRAP;
      default:  w_next = S_TRAP;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_RESET;
    end else begin
      r_state <= w_next;
    end
  end

  // Counts idle cycles of the current access; zero outside one.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wait <= '0;
    end else if (w_in_acc && !m.mem_ready
                 && (w_next == r_state)) begin
      r_wait <= r_wait + 1'b1;
    end else begin
      r_wait <= '0;
    end
  end

  always_comb begin
    m.mem_req      = 1'b0;
    m.mem_we       = 1'b0;
    m.mem_addr_sel = 1'b0;
    ir_we          = 1'b0;
    pc_we          = 1'b0;
    pc_sel         = 1'b0;
    alu_a_sel      = 1'b0;
    alu_b_sel      = 1'b0;
    reg_we         = 1'b0;
    wb_sel         = 2'd0;
    case (r_state)
      S_FETCH: begin
        m.mem_req = 1'b1;
        ir_we     = m.mem_ready;
      end
      S_EXEC: begin
        alu_a_sel = w_auipc | w_jal | w_br;
        alu_b_sel = ~w_lui;
        pc_we     = w_br;
        pc_sel    = w_br & br_taken;
      end
      S_MEM: begin
        m.mem_req      = 1'b1;
        m.mem_addr_sel = 1'b1;
        m.mem_we       = w_st;
        pc_we          = w_st & m.mem_ready;
      end
      S_WB: begin
        reg_we = 1'b1;
        pc_we  = 1'b1;
        pc_sel = w_jal;
        unique case (1'b1)
          w_ld:    wb_sel = 2'd1;
          w_jal:   wb_sel = 2'd2;
          w_lui:   wb_sel = 2'd3;
          default: wb_sel = 2'd0;
        endcase
      end
      default: ;
    endcase
  end

  assign trap  = (r_state == S_TRAP);
  assign state = r_state;

`ifdef CTRL_PERF_CNT_EN
  logic        w_retire;
  logic [31:0] r_instret;

  assign w_retire = (r_state == S_WB)
                 || ((r_state == S_EXEC) && w_br)
                 || ((r_state == S_MEM) && w_st && m.mem_ready);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_instret <= '0;
    end else if (w_retire) begin
      r_instret <= r_instret + 32'd1;
    end
  end

  assign instret = r_instret;
`else
  assign instret = 32'h0;
`endif

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Randomized bench for multicycle_ctrl against a phase-level model.
// Build with or without CTRL_PERF_CNT_EN; instret expectation follows.
module tb_multicycle_ctrl;

  localparam int TMO = 15;

  localparam logic [6:0] OPIMM = 7'b0010011;
  localparam logic [6:0] LD    = 7'b0000011;
  localparam logic [6:0] ST    = 7'b0100011;
  localparam logic [6:0] BR    = 7'b1100011;
  localparam logic [6:0] LUI   = 7'b0110111;
  localparam logic [6:0] AUIPC = 7'b0010111;
  localparam logic [6:0] JAL   = 7'b1101111;

  typedef struct packed {
    logic [2:0] st;
    logic       req;
    logic       we;
    logic       as;
    logic       ir;
    logic       pw;
    logic       ps;
    logic       aa;
    logic       ab;
    logic       rw;
    logic [1:0] wb;
    logic       tr;
  } ctl_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [6:0]  opcode = '0;
  logic        br_taken = 1'b0;
  logic        ir_we, pc_we, pc_sel;
  logic        alu_a_sel, alu_b_sel, reg_we;
  logic [1:0]  wb_sel;
  logic        trap;
  logic [2:0]  state;
  logic [31:0] instret;

  int n_chk = 0;
  int n_err = 0;
  int n_ret = 0;

  logic [6:0] ops [7] = '{OPIMM, LD, ST, BR, LUI, AUIPC, JAL};

  multicycle_ctrl_if mif ();

  multicycle_ctrl #(.MEM_TIMEOUT(TMO)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .m         (mif),
    .opcode    (opcode),
    .br_taken  (br_taken),
    .ir_we     (ir_we),
    .pc_we     (pc_we),
    .pc_sel    (pc_sel),
    .alu_a_sel (alu_a_sel),
    .alu_b_sel (alu_b_sel),
    .reg_we    (reg_we),
    .wb_sel    (wb_sel),
    .trap      (trap),
    .state     (state),
    .instret   (instret)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%h exp=%h t=%0t",
               tag, got, exp, $time);
    end
  endtask

  function automatic logic [31:0] exp_instret();
`ifdef CTRL_PERF_CNT_EN
    return 32'(n_ret);
`else
    return 32'h0;
`endif
  endfunction

  function automatic ctl_t mk(input int st);
    ctl_t c;
    c = '0;
    c.st = 3'(st);
    return c;
  endfunction

  function automatic ctl_t actual();
    return {state, mif.mem_req, mif.mem_we, mif.mem_addr_sel,
            ir_we, pc_we, pc_sel, alu_a_sel, alu_b_sel,
            reg_we, wb_sel, trap};
  endfunction

  // One clock cycle: drive inputs, compare, then account retirement.
  task automatic cyc(input string tag, input logic rdy,
                     input logic br, input logic [6:0] op,
                     input ctl_t e, input bit ret);
    @(negedge clk);
    mif.mem_ready = rdy;
    br_taken = br;
    opcode = op;
    #1;
    chk(tag, 32'(actual()), 32'(e));
    chk({tag, "/instret"}, instret, exp_instret());
    if (ret) n_ret++;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    mif.mem_ready = 1'b0;
    #1;
    n_ret = 0;
    chk("async_rst", 32'(actual()), 32'(mk(0)));
    chk("async_rst/instret", instret, 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk("reset", 32'(actual()), 32'(mk(0)));
  endtask

  // A memory access phase that completes after d idle cycles.
  task automatic access(input bit is_mem, input logic [6:0] op,
                        input int d, output bit to);
    ctl_t e;
    logic r;
    to = 1'b0;
    for (int k = 0; k < TMO; k++) begin
      r = (k == d);
      e = mk(is_mem ? 4 : 1);
      e.req = 1'b1;
      e.as  = is_mem;
      e.we  = is_mem && (op == ST);
      e.ir  = !is_mem && r;
      e.pw  = is_mem && r && (op == ST);
      cyc(is_mem ? "mem" : "fetch", r, 1'($urandom),
          is_mem ? op : 7'($urandom), e,
          is_mem && r && (op == ST));
      if (r) return;
    end
    to = 1'b1;
  endtask

  task automatic trap_hold(input int n);
    ctl_t e;
    e = mk(6);
    e.tr = 1'b1;
    for (int k = 0; k < n; k++)
      cyc("trap", 1'($urandom), 1'($urandom),
          7'($urandom), e, 1'b0);
  endtask

  task automatic run_instr(input logic [6:0] op, input int fd,
                           input int md, input logic br,
                           output bit trapped);
    ctl_t e;
    bit to;
    trapped = 1'b0;
    access(1'b0, op, fd, to);
    if (to) begin trapped = 1'b1; return; end
    cyc("decode", 1'b0, br, op, mk(2), 1'b0);
    if (!(op inside {OPIMM, LD, ST, BR, LUI, AUIPC, JAL})) begin
      trapped = 1'b1;
      return;
    end
    e = mk(3);
    e.aa = op inside {AUIPC, JAL, BR};
    e.ab = (op != LUI);
    e.pw = (op == BR);
    e.ps = (op == BR) && br;
    cyc("exec", 1'b0, br, op, e, op == BR);
    if (op == BR) return;
    if (op == LD || op == ST) begin
      access(1'b1, op, md, to);
      if (to) begin trapped = 1'b1; return; end
      if (op == ST) return;
    end
    e = mk(5);
    e.rw = 1'b1;
    e.pw = 1'b1;
    e.ps = (op == JAL);
    e.wb = (op == LD) ? 2'd1 : (op == JAL) ? 2'd2
         : (op == LUI) ? 2'd3 : 2'd0;
    cyc("wb", 1'b0, br, op, e, 1'b1);
  endtask

  function automatic int rnd_delay();
    return ($urandom_range(0, 7) == 0) ? TMO - 1
                                       : int'($urandom_range(0, 2));
  endfunction

  initial begin
    bit   t;
    ctl_t e;

    do_reset();
    run_instr(OPIMM, 1, 0, 1'b0, t);
    chk("addi_no_trap", 32'(t), 32'd0);

    run_instr(LD, 0, 3, 1'b0, t);
    run_instr(ST, 2, 0, 1'b0, t);
    run_instr(BR, 0, 0, 1'b1, t);
    run_instr(BR, 0, 0, 1'b0, t);
    run_instr(JAL, 0, 0, 1'b0, t);
    run_instr(LUI, 0, 0, 1'b0, t);
    run_instr(AUIPC, TMO - 1, 0, 1'b0, t);
    chk("ready_at_limit", 32'(t), 32'd0);

    for (int i = 0; i < 60; i++) begin
      run_instr(ops[$urandom_range(0, 6)], rnd_delay(),
                rnd_delay(), 1'($urandom), t);
      chk("rand_no_trap", 32'(t), 32'd0);
    end

    access(1'b0, 7'd0, 0, t);
    cyc("decode", 1'b0, 1'b0, LD, mk(2), 1'b0);
    e = mk(3);
    e.ab = 1'b1;
    cyc("exec", 1'b0, 1'b0, LD, e, 1'b0);
    e = mk(4);
    e.req = 1'b1;
    e.as = 1'b1;
    cyc("mem", 1'b0, 1'b0, LD, e, 1'b0);
    do_reset();

    run_instr(7'b0110011, 0, 0, 1'b0, t);
    chk("illegal_trap", 32'(t), 32'd1);
    trap_hold(22);
    do_reset();

    run_instr(OPIMM, 1000, 0, 1'b0, t);
    chk("fetch_timeout", 32'(t), 32'd1);
    trap_hold(3);
    do_reset();

    run_instr(ST, 0, 1000, 1'b0, t);
    chk("mem_timeout", 32'(t), 32'd1);
    trap_hold(3);
    do_reset();

    run_instr(LD, 0, 0, 1'b0, t);
    run_instr(ST, 0, 0, 1'b0, t);
    run_instr(BR, 0, 0, 1'b1, t);
    access(1'b0, 7'd0, 0, t);

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end

endmodule
